// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the SRAM sequencer/arbiter.
// The tag id field is sized generously so any practical NumReq fits.
package sram_arbiter_pkg;

    localparam int AddrWidth   = 14;
    localparam int DataWidth   = 8;
    localparam int SramLatency = 2;

    // Wide enough for up to 256 requesters; upper bits stay zero for small NumReq.
    localparam int TagIdWidth  = 8;

    typedef struct packed {
        logic                  valid;
        logic [TagIdWidth-1:0] id;
    } tag_t;

    // The SRAM port accesses every cycle, so idle must be a read.
    localparam logic IdleRead = 1'b1;

    localparam tag_t TagNone = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/sram_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after ptr_i, wrapping cyclically.
module rr_arbiter #(
    parameter int NumReq   = 2,
    parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NumReq-1:0]   grant_o,
    output logic [IdxWidth-1:0] grant_idx_o,
    output logic                any_o
);

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NumReq) begin
            s = s - NumReq;
        end
        return s;
    endfunction

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int off = 0; off < NumReq; off++) begin
            if (!any_o && valid_i[wrap_idx(int'(ptr_i), off)]) begin
                grant_o[wrap_idx(int'(ptr_i), off)] = 1'b1;
                grant_idx_o = IdxWidth'(wrap_idx(int'(ptr_i), off));
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sequencer for a single registered asynchronous-SRAM port, with
// an in-order tag pipeline that routes read data back to its requester.
module sram_arbiter #(
    parameter int NumReq      = 2,
    parameter int AddrWidth   = sram_arbiter_pkg::AddrWidth,
    parameter int DataWidth   = sram_arbiter_pkg::DataWidth,
    parameter int SramLatency = sram_arbiter_pkg::SramLatency
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          sram_read_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    input  logic [DataWidth-1:0]          sram_rdata_i
);
    import sram_arbiter_pkg::*;

    localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int TagStages = SramLatency + 1;

    logic [IdxWidth-1:0]  prio_q, prio_d;
    logic                 read_q, read_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    tag_t                 tag_q [TagStages];
    tag_t                 tag_d [TagStages];

    logic [NumReq-1:0]    grant;
    logic [IdxWidth-1:0]  grant_idx;
    logic                 grant_any;
    logic                 fire;

    rr_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr (
        .valid_i     (req_valid_i),
        .ptr_i       (prio_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    // Nothing may be accepted while reset holds the command registers.
    assign req_ready_o = grant & {NumReq{~rst_i}};
    assign fire        = grant_any & ~rst_i;

    always_comb begin
        prio_d   = prio_q;
        read_d   = IdleRead;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_d[0] = TagNone;
        if (fire) begin
            read_d   = ~req_we_i[grant_idx];
            addr_d   = req_addr_i[grant_idx*AddrWidth +: AddrWidth];
            wdata_d  = req_wdata_i[grant_idx*DataWidth +: DataWidth];
            prio_d   = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + IdxWidth'(1);
            tag_d[0] = '{valid: ~req_we_i[grant_idx], id: TagIdWidth'(grant_idx)};
        end
        for (int s = 1; s < TagStages; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q  <= '0;
            read_q  <= IdleRead;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int s = 0; s < TagStages; s++) begin
                tag_q[s] <= TagNone;
            end
        end else begin
            prio_q  <= prio_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            for (int s = 0; s < TagStages; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            rsp_valid_o[k] = tag_q[TagStages-1].valid &&
                             (tag_q[TagStages-1].id == TagIdWidth'(k));
        end
    end

    assign rsp_rdata_o  = sram_rdata_i;
    assign sram_read_o  = read_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule
